// File: rtl/tpdf_requantizer.sv
// TPDF-dithered requantizer with optional first-order error-feedback noise
// shaping. Time-multiplexed channels, two-stage valid/ready pipeline.
module tpdf_requantizer #(
    parameter int unsigned IN_W     = 24,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned NS_EN    = 0,
    parameter logic [31:0] SEED_A   = 32'hACE1_2468,
    parameter logic [31:0] SEED_B   = 32'h1357_BDF1,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic [CW-1:0]     in_chan,
    input  logic              in_dither_en,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CW-1:0]     out_chan,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clip_clr,
    output logic [15:0]       clip_cnt
);

    // Bits dropped by requantization, working width and error register width.
    localparam int unsigned D  = IN_W - OUT_W;
    localparam int unsigned VW = IN_W + 4;
    localparam int unsigned EW = D + 2;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Rounding offset and output clip limits in the working width.
    localparam logic signed [VW-1:0] HALF  = VW'(1) << (D - 1);
    localparam logic signed [VW-1:0] Q_MAX = (VW'(1) << (OUT_W - 1)) - VW'(1);
    localparam logic signed [VW-1:0] Q_MIN = ~Q_MAX;

    // One Galois step, right-shifting form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    logic [31:0]            lfsr_a;
    logic [31:0]            lfsr_b;

    logic                   s1_valid;
    logic signed [IN_W-1:0] s1_data;
    logic [CW-1:0]          s1_chan;
    logic signed [D:0]      s1_dither;

    logic signed [EW-1:0]   err_q [CHANNELS];

    logic                   chan_ok_c;
    logic                   accept_c;
    logic                   advance_c;
    logic                   s2_load_c;
    logic                   s2_take_c;
    logic signed [D:0]      dither_c;

    logic signed [EW-1:0]   err_cur_c;
    logic signed [VW-1:0]   v_c;
    logic signed [VW-1:0]   sum_c;
    logic signed [VW-1:0]   q_c;
    logic                   sat_c;
    logic [OUT_W-1:0]       out_next_c;
    logic signed [EW-1:0]   err_next_c;

    // Handshake: stage 2 frees when empty or drained; stage 1 frees when stage 2 loads.
    assign chan_ok_c = 32'(in_chan) < CHANNELS;
    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign accept_c  = in_valid && in_ready;
    assign advance_c = accept_c && chan_ok_c;
    assign s2_take_c = s2_load_c && s1_valid;

    // Triangular dither from the difference of two independent uniform sources.
    always_comb begin
        dither_c = '0;
        if (in_dither_en) begin
            dither_c = $signed({1'b0, lfsr_a[D-1:0]}) - $signed({1'b0, lfsr_b[D-1:0]});
        end
    end

    // Dither generators advance once per sample that will produce an output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (advance_c) begin
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
        end
    end

    // Stage 1: capture accepted sample and its dither; out-of-range channels vanish here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_chan   <= '0;
            s1_dither <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid && chan_ok_c;
            if (advance_c) begin
                s1_data   <= $signed(in_data);
                s1_chan   <= in_chan;
                s1_dither <= dither_c;
            end
        end
    end

    // Requantize: error feedback, dither, round-half-up, arithmetic shift, clip.
    always_comb begin
        err_cur_c  = '0;
        v_c        = '0;
        sum_c      = '0;
        q_c        = '0;
        sat_c      = 1'b0;
        out_next_c = '0;
        err_next_c = '0;

        if (NS_EN != 0) begin
            err_cur_c = err_q[s1_chan];
        end
        v_c   = VW'(s1_data) - VW'(err_cur_c);
        sum_c = v_c + VW'(s1_dither) + HALF;
        q_c   = sum_c >>> D;

        if (q_c > Q_MAX) begin
            sat_c      = 1'b1;
            out_next_c = OUT_W'(Q_MAX);
        end else if (q_c < Q_MIN) begin
            sat_c      = 1'b1;
            out_next_c = OUT_W'(Q_MIN);
        end else begin
            out_next_c = OUT_W'(q_c);
        end

        // A clipped sample would feed back a huge error; restart shaping instead.
        if (!sat_c) begin
            err_next_c = EW'((q_c <<< D) - v_c);
        end
    end

    // Stage 2: output register, held while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= out_next_c;
                out_chan <= s1_chan;
                out_sat  <= sat_c;
            end
        end
    end

    // Per-channel quantization error, written as the sample leaves stage 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                err_q[c] <= '0;
            end
        end else if ((NS_EN != 0) && s2_take_c) begin
            err_q[s1_chan] <= err_next_c;
        end
    end

    // Saturating clip counter; a clear coinciding with a clip leaves a count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip_cnt <= '0;
        end else if (clip_clr) begin
            clip_cnt <= (s2_take_c && sat_c) ? 16'd1 : 16'd0;
        end else if (s2_take_c && sat_c && (clip_cnt != 16'hFFFF)) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end

endmodule
